// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes,
// the "no register" ID and the run-state enum of the control unit.
package y86_pkg;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE    = 4'hF;

    localparam logic [2:0] S_BUB    = 3'd0;
    localparam logic [2:0] S_AOK    = 3'd1;
    localparam logic [2:0] S_HLT    = 3'd2;
    localparam logic [2:0] S_ADR    = 3'd3;
    localparam logic [2:0] S_INS    = 3'd4;

    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } run_state_e;

    // Any status that stops the machine.
    function automatic logic is_exc(input logic [2:0] stat);
        return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
    endfunction

endpackage

// File: rtl/pipe_hazard.sv
// Combinational hazard detection and the stall/bubble equations
// used while the core is running or draining.
module pipe_hazard
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    input  logic [2:0] m_stat,
    input  logic [2:0] W_stat,
    output logic       loaduse,
    output logic       f_stall,
    output logic       d_stall,
    output logic       d_bubble,
    output logic       e_bubble,
    output logic       m_bubble,
    output logic       w_stall,
    output logic       set_cc
);

    logic ret_in;
    logic mispred;
    logic m_exc;
    logic w_exc;

    // Hazard terms and the run-mode control equations.
    always_comb begin
        loaduse  = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ))
                   && (E_dstM != RNONE)
                   && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        ret_in   = (D_icode == I_RET) || (E_icode == I_RET)
                   || (M_icode == I_RET);
        mispred  = (E_icode == I_JXX) && !e_Cnd;
        m_exc    = is_exc(m_stat);
        w_exc    = is_exc(W_stat);
        f_stall  = loaduse || ret_in;
        d_stall  = loaduse;
        d_bubble = mispred || (!loaduse && ret_in);
        e_bubble = mispred || loaduse;
        m_bubble = m_exc || w_exc;
        w_stall  = w_exc;
        set_cc   = (E_icode == I_OPQ) && !m_exc && !w_exc;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: run-state FSM (flush, run, drain, halt),
// per-stage stall/bubble muxing, cpu status and perf counters.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int FLUSH_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_dstM,
    input  logic        e_Cnd,
    input  logic [3:0]  M_icode,
    input  logic [2:0]  m_stat,
    input  logic [2:0]  W_stat,
    output logic        F_stall,
    output logic        D_stall,
    output logic        E_stall,
    output logic        M_stall,
    output logic        W_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        M_bubble,
    output logic        set_cc,
    output logic [2:0]  cpu_stat,
    output logic        halted,
    output logic [63:0] cycle_cnt,
    output logic [63:0] retire_cnt,
    output logic [63:0] stall_cnt
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);

    run_state_e    state;
    run_state_e    state_nxt;
    logic [CW-1:0] flush_cnt;

    logic loaduse;
    logic h_f_stall;
    logic h_d_stall;
    logic h_d_bubble;
    logic h_e_bubble;
    logic h_m_bubble;
    logic h_w_stall;
    logic h_set_cc;
    logic running;

    pipe_hazard u_hazard (
        .D_icode  (D_icode),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .E_icode  (E_icode),
        .E_dstM   (E_dstM),
        .e_Cnd    (e_Cnd),
        .M_icode  (M_icode),
        .m_stat   (m_stat),
        .W_stat   (W_stat),
        .loaduse  (loaduse),
        .f_stall  (h_f_stall),
        .d_stall  (h_d_stall),
        .d_bubble (h_d_bubble),
        .e_bubble (h_e_bubble),
        .m_bubble (h_m_bubble),
        .w_stall  (h_w_stall),
        .set_cc   (h_set_cc)
    );

    // State register and post-reset flush down-counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_FLUSH;
            flush_cnt <= FLUSH_LOAD;
        end else begin
            state <= state_nxt;
            if (state == ST_FLUSH && flush_cnt != '0)
                flush_cnt <= flush_cnt - 1'b1;
        end
    end

    // Next state and per-state output muxing.
    always_comb begin
        state_nxt = state;
        F_stall   = 1'b0;
        D_stall   = 1'b0;
        E_stall   = 1'b0;
        M_stall   = 1'b0;
        W_stall   = 1'b0;
        D_bubble  = 1'b0;
        E_bubble  = 1'b0;
        M_bubble  = 1'b0;
        set_cc    = 1'b0;
        halted    = 1'b0;
        running   = 1'b0;
        unique case (state)
            ST_FLUSH: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                if (flush_cnt == '0)
                    state_nxt = ST_RUN;
            end
            ST_RUN, ST_DRAIN: begin
                running  = 1'b1;
                F_stall  = h_f_stall;
                D_stall  = h_d_stall;
                W_stall  = h_w_stall;
                D_bubble = h_d_bubble;
                E_bubble = h_e_bubble;
                M_bubble = h_m_bubble;
                set_cc   = h_set_cc;
                if (is_exc(W_stat))
                    state_nxt = ST_HALTED;
                else if (state == ST_RUN && is_exc(m_stat))
                    state_nxt = ST_DRAIN;
            end
            ST_HALTED: begin
                F_stall = 1'b1;
                D_stall = 1'b1;
                E_stall = 1'b1;
                M_stall = 1'b1;
                W_stall = 1'b1;
                halted  = 1'b1;
            end
            default: state_nxt = ST_FLUSH;
        endcase
    end

    // Architectural status captured on entry to HALTED.
    always_ff @(posedge clk) begin
        if (reset)
            cpu_stat <= S_AOK;
        else if (state != ST_HALTED && state_nxt == ST_HALTED)
            cpu_stat <= W_stat;
    end

    // Free-running performance counters, frozen outside RUN/DRAIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            stall_cnt  <= '0;
        end else if (running) begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (W_stat == S_AOK)
                retire_cnt <= retire_cnt + 64'd1;
            if (state == ST_RUN && loaduse)
                stall_cnt <= stall_cnt + 64'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard/halt scenarios followed by
// random stimulus, all checked against a behavioural model.
module tb_pipe_ctrl;

    localparam int FC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic        e_Cnd;
    logic [2:0]  m_stat, W_stat;
    logic        F_stall, D_stall, E_stall, M_stall, W_stall;
    logic        D_bubble, E_bubble, M_bubble, set_cc, halted;
    logic [2:0]  cpu_stat;
    logic [63:0] cycle_cnt, retire_cnt, stall_cnt;

    // staged stimulus for the next cycle
    logic        s_rst;
    logic [3:0]  s_Di, s_sa, s_sb, s_Ei, s_Edm, s_Mi;
    logic        s_cnd;
    logic [2:0]  s_ms, s_Ws;

    // behavioural model
    int          m_flush;
    bit          m_drain, m_hlt;
    logic [2:0]  m_stat_r;
    logic [63:0] m_cyc, m_ret, m_stl;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall),
        .M_stall(M_stall), .W_stall(W_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .set_cc(set_cc), .cpu_stat(cpu_stat), .halted(halted),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit exc(input logic [2:0] s);
        return s == 3'd2 || s == 3'd3 || s == 3'd4;
    endfunction

    function automatic bit lu_now();
        return (s_Ei == 4'h5 || s_Ei == 4'hB) && s_Edm != 4'hF &&
               (s_Edm == s_sa || s_Edm == s_sb);
    endfunction

    task automatic quiet();
        s_rst = 0; s_Di = 4'h1; s_Ei = 4'h1; s_Mi = 4'h1;
        s_sa = 4'hF; s_sb = 4'hF; s_Edm = 4'hF; s_cnd = 1;
        s_ms = 3'd1; s_Ws = 3'd1;
    endtask

    task automatic check_model();
        logic [9:0] exp;
        bit lu, rt, mp, em, ew, opq;
        lu  = lu_now();
        rt  = s_Di == 4'h9 || s_Ei == 4'h9 || s_Mi == 4'h9;
        mp  = s_Ei == 4'h7 && !s_cnd;
        em  = exc(s_ms);
        ew  = exc(s_Ws);
        opq = s_Ei == 4'h6;
        if (m_hlt)
            exp = 10'b11111_000_0_1;
        else if (m_flush > 0)
            exp = 10'b10000_111_0_0;
        else
            exp = {lu || rt, lu, 1'b0, 1'b0, ew,
                   mp || (!lu && rt), mp || lu, em || ew,
                   opq && !em && !ew, 1'b0};
        chk("ctl", {F_stall, D_stall, E_stall, M_stall, W_stall,
                    D_bubble, E_bubble, M_bubble, set_cc, halted}, exp);
        chk("cpu_stat", 64'(cpu_stat), 64'(m_stat_r));
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("retire_cnt", retire_cnt, m_ret);
        chk("stall_cnt", stall_cnt, m_stl);
        chk("no_stall_and_bubble",
            64'({D_stall & D_bubble, E_stall & E_bubble,
                 M_stall & M_bubble}), 64'd0);
    endtask

    task automatic update_model();
        if (s_rst) begin
            m_flush = FC; m_drain = 0; m_hlt = 0; m_stat_r = 3'd1;
            m_cyc = 0; m_ret = 0; m_stl = 0;
        end else if (m_flush > 0) begin
            m_flush--;
        end else if (!m_hlt) begin
            m_cyc++;
            if (s_Ws == 3'd1) m_ret++;
            if (!m_drain && lu_now()) m_stl++;
            if (exc(s_Ws)) begin
                m_hlt = 1; m_stat_r = s_Ws;
            end else if (exc(s_ms)) begin
                m_drain = 1;
            end
        end
    endtask

    // One clock: apply staged inputs after the edge, check mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
        reset = s_rst; D_icode = s_Di; d_srcA = s_sa; d_srcB = s_sb;
        E_icode = s_Ei; E_dstM = s_Edm; e_Cnd = s_cnd; M_icode = s_Mi;
        m_stat = s_ms; W_stat = s_Ws;
        #3;
        if (!s_rst) check_model();
        update_model();
    endtask

    function automatic logic [2:0] rnd_stat(input int exc_pct);
        int r;
        r = $urandom % 100;
        if (r < exc_pct) return 3'(2 + ($urandom % 3));
        if (r < exc_pct + 15) return 3'd0;
        return 3'd1;
    endfunction

    function automatic logic [3:0] rnd_icode();
        logic [3:0] pool [7];
        pool = '{4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h0};
        return pool[$urandom % 7];
    endfunction

    function automatic logic [3:0] rnd_reg();
        int r;
        r = $urandom % 5;
        return (r == 4) ? 4'hF : 4'(r);
    endfunction

    logic [63:0] r0, c0, s0, k0, k1, k2;
    int hcnt;

    initial begin
        reset = 1; D_icode = 0; d_srcA = 0; d_srcB = 0; E_icode = 0;
        E_dstM = 0; e_Cnd = 0; M_icode = 0; m_stat = 0; W_stat = 0;
        m_flush = FC; m_drain = 0; m_hlt = 0; m_stat_r = 3'd1;
        m_cyc = 0; m_ret = 0; m_stl = 0;

        quiet(); s_rst = 1;
        step(); step();
        quiet();
        for (int i = 0; i < FC; i++) begin
            step();
            chk("flush_fstall", 64'(F_stall), 64'd1);
            chk("flush_bubbles", 64'({D_bubble, E_bubble, M_bubble}),
                64'd7);
        end
        step();
        chk("run_after_flush", 64'({F_stall, D_bubble}), 64'd0);
        chk("cnt_zero_at_run", cycle_cnt, 64'd0);

        s_Ei = 4'h5; s_Edm = 4'd3; s_sa = 4'd3;
        s0 = stall_cnt;
        step();
        chk("lu_stalls", 64'({F_stall, D_stall, E_bubble, D_bubble}),
            64'b1110);
        quiet(); step();
        chk("lu_stall_cnt", stall_cnt - s0, 64'd1);

        s_Ei = 4'h7; s_cnd = 0; step();
        chk("mispred", 64'({D_bubble, E_bubble, F_stall}), 64'b110);
        s_Di = 4'h9; step();
        chk("mispred_ret", 64'({D_bubble, F_stall}), 64'b11);

        quiet();
        for (int i = 0; i < 10; i++) begin
            s_Ws = (i == 3 || i == 6) ? 3'd0 : 3'd1;
            step();
            if (i == 0) begin r0 = retire_cnt; c0 = cycle_cnt; end
        end
        quiet(); step();
        chk("retire10", retire_cnt - r0, 64'd8);
        chk("cycle10", cycle_cnt - c0, 64'd10);

        s_ms = 3'd2; step();
        chk("halt_t_mbubble", 64'({M_bubble, halted}), 64'b10);
        quiet(); s_Ws = 3'd2; step();
        chk("halt_t1_wstall", 64'({W_stall, M_bubble}), 64'b11);
        quiet(); step();
        chk("halt_t2", 64'({halted, cpu_stat}), 64'b1_010);
        k0 = cycle_cnt; k1 = retire_cnt; k2 = stall_cnt;
        for (int i = 0; i < 3; i++) begin
            s_Ei = 4'h5; s_Edm = 4'd2; s_sa = 4'd2; step();
        end
        chk("frozen_cnt", {cycle_cnt ^ k0} | {retire_cnt ^ k1}
                          | {stall_cnt ^ k2}, 64'd0);
        quiet(); s_rst = 1; step();
        quiet(); step();
        chk("reset_from_halt", 64'({halted, cpu_stat, F_stall}),
            64'b0_001_1);
        chk("reset_cnt", cycle_cnt | retire_cnt | stall_cnt, 64'd0);

        hcnt = 0;
        for (int n = 0; n < 1500; n++) begin
            s_rst = (hcnt > 4) || ($urandom % 250 == 0);
            s_Di = rnd_icode(); s_Ei = rnd_icode(); s_Mi = rnd_icode();
            s_sa = rnd_reg(); s_sb = rnd_reg(); s_Edm = rnd_reg();
            s_cnd = 1'($urandom % 2);
            s_ms = rnd_stat(2); s_Ws = rnd_stat(1);
            step();
            hcnt = m_hlt ? hcnt + 1 : 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 core. It generates the per-stage stall and bubble signals that drive the F, D, E, M and W pipeline registers, including load/use, mispredicted-branch and `ret` hazards. It also owns the processor run state: a post-reset flush, then run, drain on exception, and halt. It sits beside the pipeline registers and keeps 64-bit performance counters.

## Interface
Parameters:
- FLUSH_CYCLES, 4, number of post-reset cycles during which all stages are bubbled.

Ports:
- clk  in  1  rising-edge clock shared by all pipeline registers.
- reset  in  1  synchronous, active-high reset.
- D_icode  in  4  icode in D register.
- d_srcA, d_srcB  in  4 each  decode-stage source register IDs (0xF = RNONE).
- E_icode  in  4  icode in E register.
- E_dstM  in  4  memory destination register in E.
- e_Cnd  in  1  branch condition computed in execute.
- M_icode  in  4  icode in M register.
- m_stat  in  3  status leaving memory stage.
- W_stat  in  3  status in W register.
- F_stall, D_stall, E_stall, M_stall, W_stall  out  1 each  hold the register.
- D_bubble, E_bubble, M_bubble  out  1 each  load a NOP with stat BUB.
- set_cc  out  1  enable condition-code update in execute.
- cpu_stat  out  3  architectural status.
- halted  out  1  core frozen.
- cycle_cnt, retire_cnt, stall_cnt  out  64 each  performance counters.

## Operation
- Codes: stat BUB=0, AOK=1, HLT=2, ADR=3, INS=4. icode NOP=1, OPQ=6, JXX=7, RET=9, MRMOVQ=5, POPQ=0xB. EXC means stat in {HLT, ADR, INS}.
- Hazard terms:
  - loaduse = E_icode∈{MRMOVQ,POPQ} && E_dstM≠RNONE && E_dstM∈{d_srcA,d_srcB}.
  - ret_in = RET∈{D_icode,E_icode,M_icode}.
  - mispred = E_icode==JXX && !e_Cnd.
- FSM states: FLUSH, RUN, DRAIN, HALTED.
- FLUSH
  - Outputs: F_stall=1, D_bubble=E_bubble=M_bubble=1, all other stalls 0, set_cc=0.
  - A down-counter loads FLUSH_CYCLES-1 on reset. The state moves to RUN when the counter is 0.
- RUN/DRAIN outputs:
  - F_stall = loaduse || ret_in.
  - D_stall = loaduse.
  - D_bubble = mispred || (!loaduse && ret_in).
  - E_bubble = mispred || loaduse.
  - M_bubble = EXC(m_stat) || EXC(W_stat).
  - W_stall = EXC(W_stat).
  - E_stall = M_stall = 0.
  - set_cc = E_icode==OPQ && !EXC(m_stat) && !EXC(W_stat).
- Transitions:
  - RUN→DRAIN when EXC(m_stat).
  - RUN or DRAIN→HALTED when EXC(W_stat). This transition takes priority over RUN→DRAIN.
  - HALTED is left only by reset.
- HALTED outputs: all five stalls 1, all bubbles 0, set_cc=0, halted=1.
- cpu_stat:
  - AOK in FLUSH, RUN and DRAIN.
  - On entry to HALTED, registers W_stat and holds it.
- Counters (wrap at 2^64):
  - cycle_cnt increments each cycle in RUN or DRAIN.
  - retire_cnt increments when state is RUN or DRAIN and W_stat==AOK.
  - stall_cnt increments when state is RUN and loaduse=1.
- Invariant: a register never has stall and bubble both 1.

## Timing
- On reset (synchronous):
  - state=FLUSH, flush counter loaded, all counters 0, cpu_stat=AOK, halted=0.
  - Combinational outputs take their FLUSH values in the same cycle.
- Hazard outputs are combinational from the stage inputs, with zero latency. They are gated by the registered state.
- The first RUN cycle is exactly FLUSH_CYCLES cycles after the cycle in which reset is sampled low.
- Halt timing: EXC in m_stat at cycle t gives DRAIN at t+1. With W_stat EXC at t+1, the state is HALTED at t+2, cpu_stat is valid and halted=1 at t+2.
- Counters and cpu_stat are registered, so they update one cycle after the qualifying condition.
- Reset asserted mid-run or in HALTED: at the next edge the block returns to FLUSH. Counters clear the same edge.

## Structure
- Package y86_pkg holds the icode, stat and RNONE constants and the FSM state enum. It is shared with the pipeline-register and stage modules.
- Sub-module pipe_hazard: purely combinational loaduse, ret_in and mispred terms plus the RUN-mode stall/bubble equations.
- pipe_ctrl holds the FSM, flush counter, cpu_stat register and counters, and muxes outputs by state.

## Test plan
- Reset with FLUSH_CYCLES=4 → bubbles and F_stall high for exactly 4 cycles, then RUN; counters 0.
- E_icode=MRMOVQ, E_dstM=3, d_srcA=3 → F_stall=D_stall=E_bubble=1, D_bubble=0, stall_cnt +1.
- E_icode=JXX, e_Cnd=0 → D_bubble=E_bubble=1, F_stall=0. Same cycle with D_icode=RET → still D_bubble=1, F_stall=1.
- m_stat=HLT at t, then W_stat=HLT at t+1 → M_bubble=1 at t; W_stall=1 at t+1; halted=1, cpu_stat=2 at t+2; all stalls high afterward, counters frozen.
- W_stat=AOK for 10 RUN cycles, with W_stat=BUB on 2 of them → retire_cnt=8, cycle_cnt=10.
- Reset asserted while HALTED → FLUSH next cycle, halted=0, cpu_stat=AOK, counters 0.
